// File: rtl/selector_consignas_pkg.sv
// Shared widths, mode encoding and repeat-FSM states for the setpoint selector.
package selector_consignas_pkg;

    localparam int unsigned FREQ_W = 8;
    localparam int unsigned CORR_W = 10;

    localparam logic CONTROL_FREC = 1'b1;
    localparam logic CONTROL_CORR = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StPrimero,
        StRepetir
    } estado_e;

    // Width of a down-counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/selector_consignas_antirrebote.sv
// Two-flop synchronizer followed by a debounce counter for one raw push-button.
module antirrebote #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic nivel_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            nivel_q, nivel_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            nivel_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            nivel_q <= nivel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Level flips on the sample after DEBOUNCE_CYCLES differing samples; any match restarts.
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (sync2_q != nivel_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
                nivel_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign nivel_o = nivel_q;

endmodule

// File: rtl/selector_consignas.sv
// Debounced button entry of frequency/current setpoints with auto-repeat and mode toggle.
module selector_consignas
    import selector_consignas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000,
    parameter int unsigned FREQ_MAX        = 200,
    parameter int unsigned CORR_MAX        = 1000,
    parameter int unsigned FREQ_INIT       = 50,
    parameter int unsigned CORR_INIT       = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_arriba,
    input  logic              btn_abajo,
    input  logic              btn_modo,
    output logic [FREQ_W-1:0] frecuencia,
    output logic [CORR_W-1:0] corriente,
    output logic              control,
    output logic              cambio
);

    localparam int unsigned TimerW =
        cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

    logic arriba, abajo, modo;
    logic arriba_prev_q, abajo_prev_q, modo_prev_q;
    logic sube, baja, modo_sube;

    estado_e           estado_q, estado_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              dir_q, dir_d;
    logic              bloqueo_q, bloqueo_d;
    logic              paso;

    logic [FREQ_W-1:0] frec_q, frec_d;
    logic [CORR_W-1:0] corr_q, corr_d;
    logic              control_q, control_d;
    logic              cambio_q, cambio_d;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arriba (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (btn_arriba),
        .nivel_o (arriba)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abajo (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (btn_abajo),
        .nivel_o (abajo)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_modo (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (btn_modo),
        .nivel_o (modo)
    );

    assign sube      = arriba & ~arriba_prev_q;
    assign baja      = abajo & ~abajo_prev_q;
    assign modo_sube = modo & ~modo_prev_q;

    logic ambos, liberado, cancela, expira, arranque;

    assign ambos    = arriba & abajo;
    // dir_q = 1 means arriba is the button driving the current repeat sequence.
    assign liberado = dir_q ? ~arriba : ~abajo;
    assign cancela  = modo_sube | ambos | liberado;
    assign expira   = (timer_q == '0);
    assign arranque = ~modo_sube & ~bloqueo_q & ~ambos & (sube | baja);

    always_ff @(posedge clock) begin
        if (reset) begin
            arriba_prev_q <= 1'b0;
            abajo_prev_q  <= 1'b0;
            modo_prev_q   <= 1'b0;
            estado_q      <= StIdle;
            timer_q       <= '0;
            dir_q         <= 1'b0;
            bloqueo_q     <= 1'b0;
            frec_q        <= FREQ_W'(FREQ_INIT);
            corr_q        <= CORR_W'(CORR_INIT);
            control_q     <= CONTROL_FREC;
            cambio_q      <= 1'b0;
        end else begin
            arriba_prev_q <= arriba;
            abajo_prev_q  <= abajo;
            modo_prev_q   <= modo;
            estado_q      <= estado_d;
            timer_q       <= timer_d;
            dir_q         <= dir_d;
            bloqueo_q     <= bloqueo_d;
            frec_q        <= frec_d;
            corr_q        <= corr_d;
            control_q     <= control_d;
            cambio_q      <= cambio_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StIdle:    if (arranque) estado_d = StPrimero;
            StPrimero: begin
                if (cancela)     estado_d = StIdle;
                else if (expira) estado_d = StRepetir;
            end
            StRepetir: if (cancela) estado_d = StIdle;
            default:   estado_d = StIdle;
        endcase
    end

    always_comb begin
        paso    = 1'b0;
        timer_d = timer_q;
        dir_d   = dir_q;
        unique case (estado_q)
            StIdle: begin
                if (arranque) begin
                    paso    = 1'b1;
                    dir_d   = sube;
                    timer_d = TimerW'(REPEAT_DELAY - 1);
                end
            end
            StPrimero, StRepetir: begin
                if (!cancela) begin
                    if (expira) begin
                        paso    = 1'b1;
                        timer_d = TimerW'(REPEAT_RATE - 1);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            default: timer_d = '0;
        endcase
    end

    // Holding both buttons locks out stepping until both are released again.
    always_comb begin
        bloqueo_d = bloqueo_q;
        if (ambos)                 bloqueo_d = 1'b1;
        else if (!arriba && !abajo) bloqueo_d = 1'b0;
    end

    always_comb begin
        frec_d    = frec_q;
        corr_d    = corr_q;
        control_d = control_q;
        cambio_d  = 1'b0;
        if (modo_sube) begin
            control_d = ~control_q;
            cambio_d  = 1'b1;
        end else if (paso) begin
            if (control_q == CONTROL_FREC) begin
                if (dir_d && frec_q < FREQ_W'(FREQ_MAX)) begin
                    frec_d   = frec_q + 1'b1;
                    cambio_d = 1'b1;
                end else if (!dir_d && frec_q != '0) begin
                    frec_d   = frec_q - 1'b1;
                    cambio_d = 1'b1;
                end
            end else begin
                if (dir_d && corr_q < CORR_W'(CORR_MAX)) begin
                    corr_d   = corr_q + 1'b1;
                    cambio_d = 1'b1;
                end else if (!dir_d && corr_q != '0) begin
                    corr_d   = corr_q - 1'b1;
                    cambio_d = 1'b1;
                end
            end
        end
    end

    assign frecuencia = frec_q;
    assign corriente  = corr_q;
    assign control    = control_q;
    assign cambio     = cambio_q;

endmodule

// File: tb/tb_selector_consignas.sv
// Directed bench for selector_consignas with short debounce/repeat timings.
module tb_selector_consignas;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_arriba, btn_abajo, btn_modo;
    logic [7:0] frecuencia;
    logic [9:0] corriente;
    logic       control, cambio;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_cambio = 0;
    int unsigned c0;

    selector_consignas #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5),
        .FREQ_MAX        (200),
        .CORR_MAX        (1000),
        .FREQ_INIT       (50),
        .CORR_INIT       (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_arriba (btn_arriba),
        .btn_abajo  (btn_abajo),
        .btn_modo   (btn_modo),
        .frecuencia (frecuencia),
        .corriente  (corriente),
        .control    (control),
        .cambio     (cambio)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (cambio === 1'b1) n_cambio++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic press_arriba();
        btn_arriba = 1'b1;
        tick(10);
        btn_arriba = 1'b0;
        tick(10);
    endtask

    initial begin
        reset = 1'b1;
        btn_arriba = 1'b0;
        btn_abajo  = 1'b0;
        btn_modo   = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_frec", frecuencia, 50);
        check("reset_corr", corriente, 0);
        check("reset_ctrl", control, 1);

        // Idle
        c0 = n_cambio;
        tick(50);
        check("idle_frec", frecuencia, 50);
        check("idle_corr", corriente, 0);
        check("idle_ctrl", control, 1);
        check("idle_cambio", n_cambio - c0, 0);

        // Glitches
        btn_arriba = 1'b1; tick(1); btn_arriba = 1'b0; tick(10);
        btn_arriba = 1'b1; tick(3); btn_arriba = 1'b0; tick(10);
        check("glitch_frec", frecuencia, 50);

        // Clean press: update lands on edge 7
        c0 = n_cambio;
        btn_arriba = 1'b1;
        tick(7);
        check("press_before", frecuencia, 50);
        tick(1);
        check("press_frec", frecuencia, 51);
        check("press_cambio", cambio, 1);
        tick(2);
        btn_arriba = 1'b0;
        tick(10);
        check("press_pulses", n_cambio - c0, 1);

        for (int i = 0; i < 147; i++) press_arriba();
        check("pre_sat_frec", frecuencia, 198);

        // Hold toward saturation: steps at t, t+20, t+25
        c0 = n_cambio;
        btn_arriba = 1'b1;
        tick(8);
        check("sat_step1", frecuencia, 199);
        tick(19);
        check("sat_before2", frecuencia, 199);
        tick(1);
        check("sat_step2", frecuencia, 200);
        tick(5);
        check("sat_step3_cambio", cambio, 0);
        tick(27);
        btn_arriba = 1'b0;
        tick(10);
        check("sat_frec", frecuencia, 200);
        check("sat_pulses", n_cambio - c0, 2);

        // Mode toggle, then abajo at corriente=0
        btn_modo = 1'b1;
        tick(8);
        check("modo_ctrl", control, 0);
        check("modo_cambio", cambio, 1);
        tick(2);
        btn_modo = 1'b0;
        tick(10);
        c0 = n_cambio;
        btn_abajo = 1'b1;
        tick(40);
        check("abajo_sat_corr", corriente, 0);
        check("abajo_sat_pulses", n_cambio - c0, 0);
        btn_abajo = 1'b0;
        tick(10);
        btn_arriba = 1'b1;
        tick(8);
        check("corr_inc", corriente, 1);
        check("corr_frec_kept", frecuencia, 200);
        tick(2);
        btn_arriba = 1'b0;
        tick(10);

        // Both buttons together
        c0 = n_cambio;
        btn_arriba = 1'b1;
        btn_abajo  = 1'b1;
        tick(40);
        check("both_corr", corriente, 1);
        check("both_pulses", n_cambio - c0, 0);
        btn_arriba = 1'b0;
        btn_abajo  = 1'b0;
        tick(10);
        btn_abajo = 1'b1;
        tick(8);
        check("after_both_dec", corriente, 0);
        tick(2);
        btn_abajo = 1'b0;
        tick(10);
        check("after_both_pulses", n_cambio - c0, 1);

        // Reset restores frequency mode
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("rst2_ctrl", control, 1);

        // Auto-repeat on frequency, then reset inside REPETIR
        btn_arriba = 1'b1;
        tick(8);
        check("rep_step1", frecuencia, 51);
        tick(19);
        check("rep_before2", frecuencia, 51);
        tick(1);
        check("rep_step2", frecuencia, 52);
        tick(4);
        check("rep_before3", frecuencia, 52);
        tick(1);
        check("rep_step3", frecuencia, 53);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_frec", frecuencia, 50);
        check("midrst_corr", corriente, 0);
        check("midrst_ctrl", control, 1);
        check("midrst_cambio", cambio, 0);
        reset = 1'b0;
        tick(7);
        check("held_before", frecuencia, 50);
        tick(1);
        check("held_step", frecuencia, 51);
        btn_arriba = 1'b0;
        tick(10);
        check("held_final", frecuencia, 51);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/selector_consignas.md
# selector_consignas

Button-driven setpoint entry for the DPWM board. The block debounces the Nexys 3 up/down/mode push-buttons and maintains the frequency and current setpoints. It also drives the display-mode flag. Its outputs feed the PWM core and the 7-segment display encoder directly: it writes the `frecuencia`, `corriente` and `control` values that the display side reads.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — consecutive identical synchronized samples required to accept a button level (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000 — hold time before auto-repeat starts.
- REPEAT_RATE, 10_000_000 — cycles between auto-repeat steps.
- FREQ_MAX, 200 — upper saturation bound for `frecuencia`.
- CORR_MAX, 1000 — upper saturation bound for `corriente`.
- FREQ_INIT, 50 / CORR_INIT, 0 — reset values of the setpoints.

Ports:
- clock  in  1  — single system clock.
- reset  in  1  — synchronous, active-high reset.
- btn_arriba  in  1  — raw, asynchronous increment button, active-high.
- btn_abajo  in  1  — raw, asynchronous decrement button, active-high.
- btn_modo  in  1  — raw, asynchronous mode-toggle button, active-high.
- frecuencia  out  8  — frequency setpoint, registered.
- corriente  out  10  — current setpoint, registered.
- control  out  1  — 1 = frequency selected/displayed, 0 = current.
- cambio  out  1  — one-cycle pulse in the same cycle a setpoint or `control` takes its new value.

## Operation
- Each button passes through a 2-flop synchronizer, then a debounce counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive samples differ from the current debounced level. Any equal sample clears the counter.
- A rising edge of debounced `btn_modo` toggles `control` and forces the repeat FSM to IDLE.
- Step target: `frecuencia` when control=1, `corriente` when control=0. +1 for arriba, −1 for abajo.
- Saturation: no wrap. Increment at FREQ_MAX/CORR_MAX and decrement at 0 leave the value unchanged and do not pulse `cambio`.
- Repeat FSM states:
  - IDLE: single debounced arriba or abajo rises → one step, go to PRIMERO, load timer with REPEAT_DELAY.
  - PRIMERO: timer expires with button still held → step, go to REPETIR, load REPEAT_RATE.
  - REPETIR: step each time the timer expires while the button is held.
  - Any state: release of the active button → IDLE.
- Simultaneous arriba and abajo both debounced high: no step, FSM goes to IDLE. It stays there until both are released, then re-arms.
- Mode edge in the same cycle as a step: the mode toggle wins and no step occurs.
- Reset (any cycle, mid-repeat included): frecuencia=FREQ_INIT, corriente=CORR_INIT, control=1, cambio=0, FSM=IDLE, all counters 0. Synchronizer and debounced levels clear to 0.
- A button already held when reset deasserts counts as a fresh press after debounce.

## Timing
- Raw input stable from cycle 0 → debounced level changes at cycle DEBOUNCE_CYCLES+2 → setpoint/`control` and `cambio` update at cycle DEBOUNCE_CYCLES+3.
- Auto-repeat: 2nd step exactly REPEAT_DELAY cycles after the 1st step; subsequent steps every REPEAT_RATE cycles.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Shared package:
  - widths FREQ_W=8 and CORR_W=10;
  - mode encoding CONTROL_FREC=1'b1, CONTROL_CORR=1'b0;
  - repeat FSM state enum (IDLE, PRIMERO, REPETIR).
- Sub-module `antirrebote`: synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES, instantiated three times.
- Top level holds the edge detection, the repeat FSM/timer and the saturating setpoint registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset, then idle 50 cycles → frecuencia=50, corriente=0, control=1, cambio never high.
- btn_arriba 1-cycle glitch, then 3-cycle glitch → no change. Clean 10-cycle press → frecuencia=51 at cycle 7, single `cambio` pulse.
- Hold btn_arriba 60 cycles from frecuencia=198 → steps at t, t+20, t+25. Value stays at 200; only 2 `cambio` pulses.
- Press btn_modo, then hold btn_abajo with corriente=0 → control=0, corriente stays 0. Release, press btn_arriba once → corriente=1.
- Assert btn_arriba and btn_abajo together for 40 cycles → no step. Release both, press abajo → one decrement.
- Assert reset during REPETIR → next cycle shows reset values. Holding btn_arriba through reset deassert yields one step after debounce.
